// File: rtl/csr_dosyasi.sv
// Machine-mode CSR file: trap/mret redirect, counters and FP CSRs.
// Build option CSR_SAYAC64_EN widens mcycle/minstret to 64 bits and exposes mcycleh/minstreth.
module csr_dosyasi #(
    parameter logic [31:0] MISA_DEGER  = 32'h40000024,
    parameter logic [31:0] MTVEC_RESET = 32'h00000000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [11:0] csr_adres_i,
    input  logic [31:0] csr_veri_i,
    input  logic        csr_yaz_i,
    input  logic        exc_i,
    input  logic [3:0]  mcause_ic_i,
    input  logic [31:0] mepc_i,
    input  logic [31:0] mtval_i,
    input  logic        instret_i,
    input  logic        mret_i,
    input  logic [4:0]  fflags_i,
    input  logic        fflags_gecerli_i,
    input  logic [11:0] oku_adres_i,
    output logic [31:0] oku_veri_o,
    output logic        csr_gecersiz_o,
    output logic [2:0]  frm_o,
    output logic        yonlendir_o,
    output logic [31:0] yonlendir_pc_o
);
    localparam logic [11:0] A_FFLAGS   = 12'h001;
    localparam logic [11:0] A_FRM      = 12'h002;
    localparam logic [11:0] A_FCSR     = 12'h003;
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MCINH    = 12'h320;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
`ifdef CSR_SAYAC64_EN
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam int SW = 64;
`else
    localparam int SW = 32;
`endif

    logic          st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
    logic [31:0]   mtvec_q, mtvec_d, mie_q, mie_d, mscratch_q, mscratch_d;
    logic [31:0]   mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [31:0]   mcinh_q, mcinh_d;
    logic [SW-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic [2:0]    frm_q, frm_d;
    logic [4:0]    fflags_q, fflags_d;
    logic          yon_q, yon_d;
    logic [31:0]   yon_pc_q, yon_pc_d;
    logic [31:0]   mstatus_w;
    logic          yaz;

    // MPP and FS are hardwired to 2'b11: machine-only core with FP always dirty.
    assign mstatus_w = {17'b0, 2'b11, 2'b11, 3'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};
    assign yaz       = csr_yaz_i && !exc_i;

    always_comb begin
        oku_veri_o     = '0;
        csr_gecersiz_o = 1'b0;
        case (oku_adres_i)
            A_FFLAGS:    oku_veri_o = {27'b0, fflags_q};
            A_FRM:       oku_veri_o = {29'b0, frm_q};
            A_FCSR:      oku_veri_o = {24'b0, frm_q, fflags_q};
            A_MSTATUS:   oku_veri_o = mstatus_w;
            A_MISA:      oku_veri_o = MISA_DEGER;
            A_MIE:       oku_veri_o = mie_q;
            A_MTVEC:     oku_veri_o = mtvec_q;
            A_MCINH:     oku_veri_o = mcinh_q;
            A_MSCRATCH:  oku_veri_o = mscratch_q;
            A_MEPC:      oku_veri_o = mepc_q;
            A_MCAUSE:    oku_veri_o = mcause_q;
            A_MTVAL:     oku_veri_o = mtval_q;
            A_MCYCLE:    oku_veri_o = mcycle_q[31:0];
            A_MINSTRET:  oku_veri_o = minstret_q[31:0];
`ifdef CSR_SAYAC64_EN
            A_MCYCLEH:   oku_veri_o = mcycle_q[SW-1:32];
            A_MINSTRETH: oku_veri_o = minstret_q[SW-1:32];
`endif
            default:     csr_gecersiz_o = 1'b1;
        endcase
    end

    always_comb begin
        st_mie_d   = st_mie_q;
        st_mpie_d  = st_mpie_q;
        mtvec_d    = mtvec_q;
        mie_d      = mie_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcinh_d    = mcinh_q;
        mcycle_d   = mcinh_q[0] ? mcycle_q : mcycle_q + SW'(1);
        minstret_d = mcinh_q[2] ? minstret_q : minstret_q + SW'(instret_i);
        frm_d      = frm_q;
        fflags_d   = fflags_gecerli_i ? (fflags_q | fflags_i) : fflags_q;
        yon_d      = 1'b0;
        yon_pc_d   = yon_pc_q;

        // Software writes override the counter increment and fflags accrual.
        if (yaz) begin
            case (csr_adres_i)
                A_FFLAGS:    fflags_d = csr_veri_i[4:0];
                A_FRM:       frm_d    = csr_veri_i[2:0];
                A_FCSR: begin
                    frm_d    = csr_veri_i[7:5];
                    fflags_d = csr_veri_i[4:0];
                end
                A_MSTATUS: begin
                    st_mie_d  = csr_veri_i[3];
                    st_mpie_d = csr_veri_i[7];
                end
                A_MIE:       mie_d      = csr_veri_i & 32'h0000_0888;
                A_MTVEC:     mtvec_d    = {csr_veri_i[31:2], 2'b00};
                A_MCINH:     mcinh_d    = csr_veri_i & 32'h0000_0005;
                A_MSCRATCH:  mscratch_d = csr_veri_i;
                A_MEPC:      mepc_d     = {csr_veri_i[31:2], 2'b00};
                A_MCAUSE:    mcause_d   = csr_veri_i;
                A_MTVAL:     mtval_d    = csr_veri_i;
`ifdef CSR_SAYAC64_EN
                A_MCYCLE:    mcycle_d   = {mcycle_q[SW-1:32], csr_veri_i};
                A_MINSTRET:  minstret_d = {minstret_q[SW-1:32], csr_veri_i};
                A_MCYCLEH:   mcycle_d   = {csr_veri_i, mcycle_q[31:0]};
                A_MINSTRETH: minstret_d = {csr_veri_i, minstret_q[31:0]};
`else
                A_MCYCLE:    mcycle_d   = csr_veri_i;
                A_MINSTRET:  minstret_d = csr_veri_i;
`endif
                default: ;
            endcase
        end

        if (exc_i) begin
            mepc_d    = {mepc_i[31:2], 2'b00};
            mcause_d  = {28'b0, mcause_ic_i};
            mtval_d   = mtval_i;
            st_mpie_d = st_mie_q;
            st_mie_d  = 1'b0;
            yon_d     = 1'b1;
            yon_pc_d  = {mtvec_q[31:2], 2'b00};
        end else if (mret_i) begin
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
            yon_d     = 1'b1;
            yon_pc_d  = mepc_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
            mie_q      <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcinh_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
            frm_q      <= '0;
            fflags_q   <= '0;
            yon_q      <= 1'b0;
            yon_pc_q   <= '0;
        end else begin
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            mtvec_q    <= mtvec_d;
            mie_q      <= mie_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcinh_q    <= mcinh_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            frm_q      <= frm_d;
            fflags_q   <= fflags_d;
            yon_q      <= yon_d;
            yon_pc_q   <= yon_pc_d;
        end
    end

    assign frm_o          = frm_q;
    assign yonlendir_o    = yon_q;
    assign yonlendir_pc_o = yon_pc_q;
endmodule

// File: tb/tb_csr_dosyasi.sv
// Self-checking bench for csr_dosyasi: expected values queued at stimulus time, popped at observation.
`timescale 1ns/1ps
module tb_csr_dosyasi;
    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic [11:0] csr_adres_i = '0, oku_adres_i = '0;
    logic [31:0] csr_veri_i = '0, mepc_i = '0, mtval_i = '0;
    logic        csr_yaz_i = 1'b0, exc_i = 1'b0, instret_i = 1'b0, mret_i = 1'b0;
    logic [3:0]  mcause_ic_i = '0;
    logic [4:0]  fflags_i = '0;
    logic        fflags_gecerli_i = 1'b0;
    logic [31:0] oku_veri_o, yonlendir_pc_o;
    logic        csr_gecersiz_o, yonlendir_o;
    logic [2:0]  frm_o;

    csr_dosyasi dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .csr_adres_i(csr_adres_i), .csr_veri_i(csr_veri_i), .csr_yaz_i(csr_yaz_i),
        .exc_i(exc_i), .mcause_ic_i(mcause_ic_i), .mepc_i(mepc_i), .mtval_i(mtval_i),
        .instret_i(instret_i), .mret_i(mret_i),
        .fflags_i(fflags_i), .fflags_gecerli_i(fflags_gecerli_i),
        .oku_adres_i(oku_adres_i), .oku_veri_o(oku_veri_o), .csr_gecersiz_o(csr_gecersiz_o),
        .frm_o(frm_o), .yonlendir_o(yonlendir_o), .yonlendir_pc_o(yonlendir_pc_o)
    );

    always #50 clk_i = ~clk_i;

    int          n_cmp = 0, n_err = 0;
    logic [32:0] sb_q[$];
    logic [32:0] obs, exp_v;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, output logic [32:0] v);
        oku_adres_i = a;
        #1;
        v = {csr_gecersiz_o, oku_veri_o};
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_adres_i = a;
        csr_veri_i  = d;
        csr_yaz_i   = 1'b1;
        step();
        csr_yaz_i   = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] ad [9];
        logic [32:0] ex [9];
        rst_ni = 1'b0;
        #20;
        sb_q.push_back({1'b0, 32'h0});
        exp_v = sb_q.pop_front();
        obs = {yonlendir_o, yonlendir_pc_o};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_redirect got=%h want=%h", obs, exp_v); end
        @(negedge clk_i) rst_ni = 1'b1;
        step();
        ad = '{12'h300, 12'h305, 12'h301, 12'h7C0, 12'h340, 12'h342, 12'hB82, 12'h003, 12'h320};
`ifdef CSR_SAYAC64_EN
        ex = '{{1'b0, 32'h00007800}, {1'b0, 32'h0}, {1'b0, 32'h40000024}, {1'b1, 32'h0},
               {1'b0, 32'h0}, {1'b0, 32'h0}, {1'b0, 32'h0}, {1'b0, 32'h0}, {1'b0, 32'h0}};
`else
        ex = '{{1'b0, 32'h00007800}, {1'b0, 32'h0}, {1'b0, 32'h40000024}, {1'b1, 32'h0},
               {1'b0, 32'h0}, {1'b0, 32'h0}, {1'b1, 32'h0}, {1'b0, 32'h0}, {1'b0, 32'h0}};
`endif
        for (int i = 0; i < 9; i++) begin
            sb_q.push_back(ex[i]);
            rd(ad[i], obs);
            exp_v = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL reset_read a=%h got=%h want=%h", ad[i], obs, exp_v); end
        end
        sb_q.push_back({1'b0, 32'h0});
        exp_v = sb_q.pop_front();
        obs = {1'b0, 29'b0, frm_o};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_frm got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_trap();
        logic [11:0] ad [4];
        logic [32:0] ex [4];
        wr(12'h305, 32'h80000103);
        wr(12'h300, 32'h00000008);
        ad = '{12'h305, 12'h300, 12'h304, 12'h304};
        ex = '{{1'b0, 32'h80000100}, {1'b0, 32'h00007808}, {1'b0, 32'h0}, {1'b0, 32'h888}};
        for (int i = 0; i < 4; i++) begin
            if (i == 3) wr(12'h304, 32'hFFFFFFFF);
            sb_q.push_back(ex[i]);
            rd(ad[i], obs);
            exp_v = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL trap_setup a=%h got=%h want=%h", ad[i], obs, exp_v); end
        end
        exc_i = 1'b1; mcause_ic_i = 4'd2; mepc_i = 32'h800001A2; mtval_i = 32'h0000DEAD;
        sb_q.push_back({1'b1, 32'h80000100});
        step();
        exc_i = 1'b0;
        obs = {yonlendir_o, yonlendir_pc_o};
        exp_v = sb_q.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL trap_redirect got=%h want=%h", obs, exp_v); end
        ad = '{12'h341, 12'h342, 12'h343, 12'h300};
        ex = '{{1'b0, 32'h800001A0}, {1'b0, 32'h2}, {1'b0, 32'hDEAD}, {1'b0, 32'h00007880}};
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(ex[i]);
            rd(ad[i], obs);
            exp_v = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL trap_state a=%h got=%h want=%h", ad[i], obs, exp_v); end
        end
        sb_q.push_back({1'b0, 32'h0});
        step();
        obs = {yonlendir_o, 32'h0};
        exp_v = sb_q.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL trap_pulse_end got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_mret();
        mret_i = 1'b1;
        sb_q.push_back({1'b1, 32'h800001A0});
        sb_q.push_back({1'b0, 32'h00007888});
        sb_q.push_back({1'b0, 32'h0});
        step();
        mret_i = 1'b0;
        obs = {yonlendir_o, yonlendir_pc_o};
        exp_v = sb_q.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL mret_redirect got=%h want=%h", obs, exp_v); end
        rd(12'h300, obs);
        exp_v = sb_q.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL mret_mstatus got=%h want=%h", obs, exp_v); end
        step();
        obs = {yonlendir_o, 32'h0};
        exp_v = sb_q.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL mret_pulse_end got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_write_drop();
        logic [11:0] ad [4];
        logic [32:0] ex [4];
        csr_adres_i = 12'h340; csr_veri_i = 32'h1234; csr_yaz_i = 1'b1;
        exc_i = 1'b1; mcause_ic_i = 4'd5; mepc_i = 32'h00000104; mtval_i = 32'h0;
        sb_q.push_back({1'b1, 32'h80000100});
        step();
        csr_yaz_i = 1'b0; exc_i = 1'b0;
        obs = {yonlendir_o, yonlendir_pc_o};
        exp_v = sb_q.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL drop_redirect got=%h want=%h", obs, exp_v); end
        ad = '{12'h340, 12'h342, 12'h341, 12'h300};
        ex = '{{1'b0, 32'h0}, {1'b0, 32'h5}, {1'b0, 32'h104}, {1'b0, 32'h00007880}};
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(ex[i]);
            rd(ad[i], obs);
            exp_v = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL drop_state a=%h got=%h want=%h", ad[i], obs, exp_v); end
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] ex [3];
        ex = '{{1'b1, 32'h80000100}, {1'b1, 32'h00000204}, {1'b0, 32'h0}};
        for (int i = 0; i < 3; i++) begin
            exc_i  = (i == 0);
            mret_i = (i == 1);
            mcause_ic_i = 4'd3; mepc_i = 32'h00000207;
            sb_q.push_back(ex[i]);
            step();
            obs = (i == 2) ? {yonlendir_o, 32'h0} : {yonlendir_o, yonlendir_pc_o};
            exp_v = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL b2b_redirect step=%0d got=%h want=%h", i, obs, exp_v); end
        end
        exc_i = 1'b0; mret_i = 1'b0;
        sb_q.push_back({1'b0, 32'h00007880});
        rd(12'h300, obs);
        exp_v = sb_q.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL b2b_mstatus got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_counters();
        logic [11:0] ad [10];
        logic [32:0] ex [10];
        ad = '{12'hB02, 12'hB82, 12'h320, 12'hB02, 12'hB02, 12'hB02, 12'hB00, 12'hB00, 12'hB00, 12'hB00};
`ifdef CSR_SAYAC64_EN
        ex = '{{1'b0, 32'h0}, {1'b0, 32'h1}, {1'b0, 32'h4}, {1'b0, 32'h7}, {1'b0, 32'h50},
               {1'b0, 32'h51}, {1'b0, 32'h100}, {1'b0, 32'h103}, {1'b0, 32'h104}, {1'b0, 32'h0}};
`else
        ex = '{{1'b0, 32'h0}, {1'b1, 32'h0}, {1'b0, 32'h4}, {1'b0, 32'h7}, {1'b0, 32'h50},
               {1'b0, 32'h51}, {1'b0, 32'h100}, {1'b0, 32'h103}, {1'b0, 32'h104}, {1'b0, 32'h0}};
`endif
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: begin wr(12'hB02, 32'hFFFFFFFF); instret_i = 1'b1; step(); instret_i = 1'b0; end
                2: wr(12'h320, 32'h00000006);
                3: begin wr(12'hB02, 32'h7); instret_i = 1'b1; step(); step(); step(); instret_i = 1'b0; end
                4: begin
                    wr(12'h320, 32'h0);
                    instret_i = 1'b1;
                    wr(12'hB02, 32'h50);
                end
                5: begin step(); instret_i = 1'b0; end
                6: wr(12'hB00, 32'h100);
                7: begin step(); step(); step(); end
                8: begin wr(12'h320, 32'h1); step(); step(); end
                9: begin wr(12'h320, 32'h0); wr(12'hB00, 32'hFFFFFFFF); step(); end
                default: ;
            endcase
            sb_q.push_back(ex[i]);
            rd(ad[i], obs);
            exp_v = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL counter step=%0d a=%h got=%h want=%h", i, ad[i], obs, exp_v); end
        end
`ifdef CSR_SAYAC64_EN
        sb_q.push_back({1'b0, 32'h1});
        rd(12'hB80, obs);
        exp_v = sb_q.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL mcycleh_carry got=%h want=%h", obs, exp_v); end
`endif
    endtask

    task automatic test_fp();
        logic [11:0] ad [6];
        logic [32:0] ex [6];
        ad = '{12'h001, 12'h003, 12'h003, 12'h002, 12'h001, 12'h003};
        ex = '{{1'b0, 32'h05}, {1'b0, 32'h05}, {1'b0, 32'h45}, {1'b0, 32'h2}, {1'b0, 32'h10}, {1'b0, 32'hE3}};
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin
                    fflags_gecerli_i = 1'b1; fflags_i = 5'h01; step();
                    fflags_i = 5'h04; step(); fflags_gecerli_i = 1'b0;
                end
                2: wr(12'h002, 32'h2);
                4: begin
                    fflags_gecerli_i = 1'b1; fflags_i = 5'h01;
                    wr(12'h001, 32'h10);
                    fflags_gecerli_i = 1'b0;
                end
                5: wr(12'h003, 32'h1E3);
                default: ;
            endcase
            sb_q.push_back(ex[i]);
            rd(ad[i], obs);
            exp_v = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL fp step=%0d a=%h got=%h want=%h", i, ad[i], obs, exp_v); end
            if (i == 2 || i == 5) begin
                sb_q.push_back((i == 2) ? 33'd2 : 33'd7);
                obs = {30'b0, frm_o};
                exp_v = sb_q.pop_front();
                n_cmp++;
                if (obs !== exp_v) begin n_err++; $display("FAIL frm_o step=%0d got=%h want=%h", i, obs, exp_v); end
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [11:0] ad [2];
        logic [32:0] ex [2];
        exc_i = 1'b1; mcause_ic_i = 4'd1; mepc_i = 32'h40;
        step();
        sb_q.push_back({1'b1, 32'h80000100});
        obs = {yonlendir_o, yonlendir_pc_o};
        exp_v = sb_q.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL abort_pre got=%h want=%h", obs, exp_v); end
        #10 rst_ni = 1'b0;
        #5;
        sb_q.push_back({1'b0, 32'h0});
        obs = {yonlendir_o, yonlendir_pc_o};
        exp_v = sb_q.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL abort_async got=%h want=%h", obs, exp_v); end
        step();
        exc_i = 1'b0;
        @(negedge clk_i) rst_ni = 1'b1;
        step();
        sb_q.push_back({1'b0, 32'h0});
        obs = {yonlendir_o, yonlendir_pc_o};
        exp_v = sb_q.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL abort_post got=%h want=%h", obs, exp_v); end
        ad = '{12'h305, 12'h300};
        ex = '{{1'b0, 32'h0}, {1'b0, 32'h00007800}};
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(ex[i]);
            rd(ad[i], obs);
            exp_v = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL abort_state a=%h got=%h want=%h", ad[i], obs, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_trap();
        test_mret();
        test_write_drop();
        test_back_to_back();
        test_counters();
        test_fp();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
